// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage constants: NOP encoding, reset PC and fetch FSM state encodings.
package instr_fetch_pkg;

    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_HELD   = 2'd1;
    localparam logic [1:0] ST_SQUASH = 2'd2;

    function automatic logic [31:0] pc_inc(input logic [31:0] p);
        return p + 32'd4;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load a fetched word, inject a NOP bubble, or hold.
// Load wins over NOP inject; pc_out/pc_plus4_out only change on a real load.
module ifid_reg
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        inject_nop,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic [31:0] instr_out,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_out    <= NOP_INSTR;
            valid_out    <= 1'b0;
            pc_out       <= 32'h0000_0000;
            pc_plus4_out <= 32'h0000_0004;
        end else if (load) begin
            instr_out    <= instr_in;
            valid_out    <= 1'b1;
            pc_out       <= pc_in;
            pc_plus4_out <= pc_inc(pc_in);
        end else if (inject_nop) begin
            instr_out    <= NOP_INSTR;
            valid_out    <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// IF stage + IF/ID register: PC, req/ack fetch FSM, redirects; 1-cycle ack->instr_out latency.
// Stall/pc_enable freeze IF/ID; an acked word is buffered (HELD) and requests are never withdrawn.
// Build option BRANCH_DELAY_SLOT_EN: deliver the word after a branch instead of squashing it.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_enable_in,
    input  logic        stall_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_target_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_data_in,
    output logic [31:0] instr_out,
    output logic        instr_valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out
);

    logic [1:0]  state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] hold_buf, hold_buf_n;
    logic [31:0] squash_addr, squash_addr_n;
    logic        advance;
    logic        ld;
    logic        nop;
    logic [31:0] ld_data;

    assign advance       = pc_enable_in & ~stall_in;
    assign imem_req_out  = ~reset & (state != ST_HELD);
    assign imem_addr_out = (state == ST_SQUASH) ? squash_addr : pc;

`ifdef BRANCH_DELAY_SLOT_EN
    logic        pend, pend_n;
    logic [31:0] pend_target, pend_target_n;
    logic [31:0] next_pc;

    // A redirect arriving this cycle counts as already pending for the delay slot.
    assign next_pc = redirect_in ? redirect_target_in :
                     pend        ? pend_target        : pc_inc(pc);

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        hold_buf_n    = hold_buf;
        squash_addr_n = squash_addr;
        pend_n        = pend;
        pend_target_n = pend_target;
        ld            = 1'b0;
        nop           = 1'b0;
        ld_data       = imem_data_in;
        if (redirect_in) begin
            pend_n        = 1'b1;
            pend_target_n = redirect_target_in;
        end
        case (state)
            ST_FETCH: begin
                if (imem_ack_in) begin
                    if (advance) begin
                        ld     = 1'b1;
                        pc_n   = next_pc;
                        pend_n = 1'b0;
                    end else begin
                        hold_buf_n = imem_data_in;
                        state_n    = ST_HELD;
                    end
                end else if (advance) begin
                    nop = 1'b1;
                end
            end
            ST_HELD: begin
                if (advance) begin
                    ld      = 1'b1;
                    ld_data = hold_buf;
                    pc_n    = next_pc;
                    pend_n  = 1'b0;
                    state_n = ST_FETCH;
                end
            end
            default: begin
                if (imem_ack_in) state_n = ST_FETCH;
                if (advance) nop = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend        <= 1'b0;
            pend_target <= 32'h0000_0000;
        end else begin
            pend        <= pend_n;
            pend_target <= pend_target_n;
        end
    end

    a_no_double_redirect: assert property (@(posedge clk) disable iff (reset)
        !(redirect_in && pend));
`else
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        hold_buf_n    = hold_buf;
        squash_addr_n = squash_addr;
        ld            = 1'b0;
        nop           = 1'b0;
        ld_data       = imem_data_in;
        case (state)
            ST_FETCH: begin
                if (redirect_in) begin
                    // The word at branch+4 is dropped; an unacked one is drained in SQUASH.
                    pc_n = redirect_target_in;
                    nop  = advance;
                    if (!imem_ack_in) begin
                        squash_addr_n = pc;
                        state_n       = ST_SQUASH;
                    end
                end else if (imem_ack_in) begin
                    if (advance) begin
                        ld   = 1'b1;
                        pc_n = pc_inc(pc);
                    end else begin
                        hold_buf_n = imem_data_in;
                        state_n    = ST_HELD;
                    end
                end else if (advance) begin
                    nop = 1'b1;
                end
            end
            ST_HELD: begin
                if (redirect_in) begin
                    pc_n    = redirect_target_in;
                    nop     = advance;
                    state_n = ST_FETCH;
                end else if (advance) begin
                    ld      = 1'b1;
                    ld_data = hold_buf;
                    pc_n    = pc_inc(pc);
                    state_n = ST_FETCH;
                end
            end
            default: begin
                if (redirect_in) pc_n = redirect_target_in;
                if (imem_ack_in) state_n = ST_FETCH;
                if (advance) nop = 1'b1;
            end
        endcase
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            hold_buf    <= 32'h0000_0000;
            squash_addr <= 32'h0000_0000;
        end else begin
            state       <= state_n;
            pc          <= {pc_n[31:2], 2'b00};
            hold_buf    <= hold_buf_n;
            squash_addr <= squash_addr_n;
        end
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk          (clk),
        .reset        (reset),
        .load         (ld),
        .inject_nop   (nop),
        .instr_in     (ld_data),
        .pc_in        (pc),
        .instr_out    (instr_out),
        .valid_out    (instr_valid_out),
        .pc_out       (pc_out),
        .pc_plus4_out (pc_plus4_out)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: stimulus pushes expected IF/ID contents, a monitor pops and compares.
module tb_instr_fetch;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit SLOT = 1'b1;
`else
    localparam bit SLOT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_enable_in;
    logic        stall_in;
    logic        redirect_in;
    logic [31:0] redirect_target_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in;
    logic [31:0] imem_data_in;
    logic [31:0] instr_out;
    logic        instr_valid_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;

    typedef struct packed {
        logic [31:0] instr;
        logic        valid;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_data_in = dat(imem_addr_out);

    instr_fetch dut (
        .clk                (clk),
        .reset              (reset),
        .pc_enable_in       (pc_enable_in),
        .stall_in           (stall_in),
        .redirect_in        (redirect_in),
        .redirect_target_in (redirect_target_in),
        .imem_req_out       (imem_req_out),
        .imem_addr_out      (imem_addr_out),
        .imem_ack_in        (imem_ack_in),
        .imem_data_in       (imem_data_in),
        .instr_out          (instr_out),
        .instr_valid_out    (instr_valid_out),
        .pc_out             (pc_out),
        .pc_plus4_out       (pc_plus4_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [31:0] i, input logic v, input logic [31:0] p);
        exp_t e;
        e.instr = i;
        e.valid = v;
        e.pc    = p;
        q.push_back(e);
    endtask

    // One clock of stimulus; request side checked directly, IF/ID expectation queued.
    task automatic step(input logic pe, input logic st, input logic ack, input logic rd,
                        input logic [31:0] tgt, input logic ereq, input logic [31:0] eaddr,
                        input logic [31:0] ei, input logic ev, input logic [31:0] ep);
        @(negedge clk);
        pc_enable_in       = pe;
        stall_in           = st;
        imem_ack_in        = ack;
        redirect_in        = rd;
        redirect_target_in = tgt;
        #1;
        chk("imem_req", {31'b0, imem_req_out}, {31'b0, ereq});
        if (ereq) chk("imem_addr", imem_addr_out, eaddr);
        if (pe && !st) push(ei, ev, ep);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_valid", {31'b0, instr_valid_out}, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_pc4", pc_plus4_out, 32'h4);
        chk("rst_req", {31'b0, imem_req_out}, 32'h0);
    endtask

    // Release on a falling edge; the first rising edge after release has no ack -> bubble.
    task automatic release_reset();
        @(negedge clk);
        chk_reset_outputs();
        reset        = 1'b0;
        imem_ack_in  = 1'b0;
        pc_enable_in = 1'b1;
        stall_in     = 1'b0;
        redirect_in  = 1'b0;
        #1;
        chk("rel_req", {31'b0, imem_req_out}, 32'h1);
        chk("rel_addr", imem_addr_out, 32'h0);
        push(32'h0, 1'b0, 32'h0);
    endtask

    // Monitor: on every advancing edge pop the next expectation, otherwise IF/ID must hold.
    initial begin
        logic adv;
        logic in_rst;
        forever begin
            @(posedge clk);
            adv    = pc_enable_in & ~stall_in;
            in_rst = reset;
            #1;
            if (!in_rst && !reset) begin
                if (adv) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_underflow: got empty queue want entry at %0t", $time);
                    end else begin
                        last_exp = q.pop_front();
                    end
                end
                chk("if_instr", instr_out, last_exp.instr);
                chk("if_valid", {31'b0, instr_valid_out}, {31'b0, last_exp.valid});
                if (last_exp.valid) begin
                    chk("if_pc", pc_out, last_exp.pc);
                    chk("if_pc4", pc_plus4_out, last_exp.pc + 32'd4);
                end
            end
        end
    end

    initial begin
        last_exp           = '0;
        reset              = 1'b1;
        pc_enable_in       = 1'b0;
        stall_in           = 1'b0;
        redirect_in        = 1'b0;
        redirect_target_in = 32'h0;
        imem_ack_in        = 1'b0;
        repeat (2) @(negedge clk);
        release_reset();

        // zero-wait streaming
        step(1, 0, 1, 0, 0, 1, 32'h00, dat(32'h00), 1, 32'h00);
        step(1, 0, 1, 0, 0, 1, 32'h04, dat(32'h04), 1, 32'h04);
        step(1, 0, 1, 0, 0, 1, 32'h08, dat(32'h08), 1, 32'h08);
        step(1, 0, 1, 0, 0, 1, 32'h0C, dat(32'h0C), 1, 32'h0C);

        // ack two cycles late: request held, two bubbles
        step(1, 0, 0, 0, 0, 1, 32'h10, 32'h0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 1, 32'h10, 32'h0, 0, 32'h0);
        step(1, 0, 1, 0, 0, 1, 32'h10, dat(32'h10), 1, 32'h10);

        // stall while ack arrives -> HELD, then drain buffer
        step(1, 1, 1, 0, 0, 1, 32'h14, 32'h0, 0, 32'h0);
        step(1, 1, 0, 0, 0, 0, 32'h00, 32'h0, 0, 32'h0);
        step(1, 1, 0, 0, 0, 0, 32'h00, 32'h0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 0, 32'h00, dat(32'h14), 1, 32'h14);
        step(1, 0, 1, 0, 0, 1, 32'h18, dat(32'h18), 1, 32'h18);

        // pc_enable low freezes everything
        step(0, 0, 0, 0, 0, 1, 32'h1C, 32'h0, 0, 32'h0);
        step(1, 0, 1, 0, 0, 1, 32'h1C, dat(32'h1C), 1, 32'h1C);

        // branch at 0x1C -> 0x40, word 0x20 still in flight
        step(1, 0, 0, 1, 32'h40, 1, 32'h20, 32'h0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 1, 32'h20, 32'h0, 0, 32'h0);
        step(1, 0, 1, 0, 0, 1, 32'h20,
             SLOT ? dat(32'h20) : 32'h0, SLOT, SLOT ? 32'h20 : 32'h0);
        step(1, 0, 1, 0, 0, 1, 32'h40, dat(32'h40), 1, 32'h40);

        // redirect with ack and advance in the same cycle, target at top of memory
        step(1, 0, 1, 1, 32'hFFFF_FFFC, 1, 32'h44,
             SLOT ? dat(32'h44) : 32'h0, SLOT, SLOT ? 32'h44 : 32'h0);
        step(1, 0, 1, 0, 0, 1, 32'hFFFF_FFFC, dat(32'hFFFF_FFFC), 1, 32'hFFFF_FFFC);
        step(1, 0, 1, 0, 0, 1, 32'h00, dat(32'h00), 1, 32'h00);

        // redirect while the next word sits in the hold buffer
        step(1, 1, 1, 0, 0, 1, 32'h04, 32'h0, 0, 32'h0);
        step(1, 1, 0, 1, 32'h80, 0, 32'h00, 32'h0, 0, 32'h0);
        step(1, 0, 1, 0, 0, !SLOT, 32'h80,
             SLOT ? dat(32'h04) : dat(32'h80), 1, SLOT ? 32'h04 : 32'h80);
        step(1, 0, 1, 0, 0, 1, SLOT ? 32'h80 : 32'h84,
             SLOT ? dat(32'h80) : dat(32'h84), 1, SLOT ? 32'h80 : 32'h84);

        // reset while a request is outstanding; stale ack during reset
        step(0, 0, 0, 0, 0, 1, SLOT ? 32'h84 : 32'h88, 32'h0, 0, 32'h0);
        @(negedge clk);
        #2;
        reset       = 1'b1;
        imem_ack_in = 1'b1;
        #1;
        chk_reset_outputs();
        last_exp = '0;
        release_reset();
        step(1, 0, 1, 0, 0, 1, 32'h00, dat(32'h00), 1, 32'h00);
        step(1, 0, 1, 0, 0, 1, 32'h04, dat(32'h04), 1, 32'h04);

        @(negedge clk);
        pc_enable_in = 1'b0;
        imem_ack_in  = 1'b0;
        @(posedge clk);
        #2;
        chk("sb_leftover", q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
